// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60Hz timing constants, framebuffer resolution table
// and the colour-channel expansion helper.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic {
    RES_160X120,
    RES_320X240
  } res_e;

  typedef struct packed {
    int unsigned w;
    int unsigned h;
    int unsigned s;
    int unsigned xw;
    int unsigned yw;
  } res_t;

  function automatic res_t res_params(res_e r);
    res_t p;
    if (r == RES_320X240) p = '{w: 320, h: 240, s: 2, xw: 9, yw: 8};
    else                  p = '{w: 160, h: 120, s: 4, xw: 8, yw: 7};
    return p;
  endfunction

  // Replicates the channel bits MSB-first until all 10 DAC bits are filled.
  function automatic logic [9:0] expand_channel(logic [3:0] ch, int unsigned bpc);
    logic [9:0] v;
    v = '0;
    for (int unsigned i = 0; i < 10; i++)
      v[4'(9 - i)] = ch[2'(bpc - 1 - (i % bpc))];
    return v;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480@60Hz scan counters: pixel-enable phase, hcount/vcount and the raw
// (undelayed) sync and visible-area signals derived from them.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       visible
);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);

  logic phase;

  // phase doubles as the 25 MHz pixel clock; counters step while it is high
  always_ff @(posedge clock) begin
    if (reset) begin
      phase  <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  assign pix_en = phase;

  always_comb begin
    hs_raw  = !(hcount >= HS_START && hcount < HS_END);
    vs_raw  = !(vcount >= VS_START && vcount < VS_END);
    visible = (hcount < H_VIS_END) && (vcount < V_VIS_END);
  end

endmodule

// File: rtl/vga_adapter.sv
// Framebuffer-backed VGA adapter: one-pixel-per-cycle write port, upscaled
// 640x480 scan-out with sync delayed to stay aligned with the memory read.
module vga_adapter
  import vga_pkg::*;
#(
  parameter string       RESOLUTION              = "160x120",
  parameter string       MONOCHROME              = "FALSE",
  parameter int unsigned BITS_PER_COLOUR_CHANNEL = 1,
  parameter string       BACKGROUND_IMAGE        = "black.mif",
  localparam res_t        RES = res_params((RESOLUTION == "320x240") ? RES_320X240 : RES_160X120),
  localparam int unsigned XW  = RES.xw,
  localparam int unsigned YW  = RES.yw,
  localparam int unsigned CW  = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CW-1:0] colour,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic          plot,
  output logic [9:0]    VGA_R,
  output logic [9:0]    VGA_G,
  output logic [9:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK,
  output logic          VGA_SYNC,
  output logic          VGA_CLK
);

  localparam int unsigned W  = RES.w;
  localparam int unsigned H  = RES.h;
  localparam int unsigned SH = $clog2(RES.s);
  localparam int unsigned AW = $clog2(W * H);

  logic       pix_phase;
  logic [9:0] hcount, vcount;
  logic       hs_raw, vs_raw, visible;

  vga_timing u_timing (
    .clock   (clock),
    .reset   (reset),
    .pix_en  (pix_phase),
    .hcount  (hcount),
    .vcount  (vcount),
    .hs_raw  (hs_raw),
    .vs_raw  (vs_raw),
    .visible (visible)
  );

  (* ram_init_file = BACKGROUND_IMAGE *) logic [CW-1:0] mem [W*H];

  logic [AW-1:0] wr_addr, rd_addr;
  logic [CW-1:0] rd_data;
  logic          wr_ok;

  always_comb begin
    wr_addr = AW'(y) * AW'(W) + AW'(x);
    wr_ok   = plot && (x < XW'(W)) && (y < YW'(H));
    rd_addr = '0;
    if (visible) rd_addr = AW'(vcount >> SH) * AW'(W) + AW'(hcount >> SH);
  end

  // Not reset: writes are accepted during reset and the read is
  // read-before-write on a same-address collision.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_addr] <= colour;
    rd_data <= mem[rd_addr];
  end

  logic hs_d, vs_d, vis_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      vis_d <= 1'b0;
    end else begin
      hs_d  <= hs_raw;
      vs_d  <= vs_raw;
      vis_d <= visible;
    end
  end

  logic [9:0] r_exp, g_exp, b_exp;

  if (CW == 1) begin : g_mono
    always_comb begin
      r_exp = expand_channel(4'(rd_data), 1);
      g_exp = r_exp;
      b_exp = r_exp;
    end
  end else begin : g_rgb
    localparam int unsigned B = BITS_PER_COLOUR_CHANNEL;
    always_comb begin
      r_exp = expand_channel(4'(rd_data[3*B-1 -: B]), B);
      g_exp = expand_channel(4'(rd_data[2*B-1 -: B]), B);
      b_exp = expand_channel(4'(rd_data[B-1 -: B]), B);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      VGA_BLANK <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      VGA_HS    <= hs_d;
      VGA_VS    <= vs_d;
      VGA_BLANK <= vis_d;
      VGA_R     <= vis_d ? r_exp : '0;
      VGA_G     <= vis_d ? g_exp : '0;
      VGA_B     <= vis_d ? b_exp : '0;
    end
  end

  assign VGA_SYNC = 1'b1;
  assign VGA_CLK  = pix_phase;

endmodule

// File: tb/tb_vga_adapter.sv
// Self-checking bench for vga_adapter (160x120, 3-bit colour): a reference
// scan model feeds a scoreboard compared against the pins every clock.
module tb_vga_adapter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] colour = '0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic       plot = 1'b0;
  logic [9:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK;

  always #10 clock = ~clock;

  vga_adapter #(
    .RESOLUTION              ("160x120"),
    .MONOCHROME              ("FALSE"),
    .BITS_PER_COLOUR_CHANNEL (1),
    .BACKGROUND_IMAGE        ("black.mif")
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .colour    (colour),
    .x         (x),
    .y         (y),
    .plot      (plot),
    .VGA_R     (VGA_R),
    .VGA_G     (VGA_G),
    .VGA_B     (VGA_B),
    .VGA_HS    (VGA_HS),
    .VGA_VS    (VGA_VS),
    .VGA_BLANK (VGA_BLANK),
    .VGA_SYNC  (VGA_SYNC),
    .VGA_CLK   (VGA_CLK)
  );

  localparam logic [33:0] IDLE = {1'b1, 1'b1, 1'b0, 30'b0};

  int compared = 0;
  int mismatched = 0;

  logic [2:0]  fb [19200];
  logic [33:0] sb [$];
  int  h, v, cyc;
  bit  ph;
  int  hs_fall1 = -1, hs_fall2 = -1, hs_rise = -1, bl_rise = -1, bl_fall = -1;
  int  lit_r, lit_b;
  logic prev_hs, prev_bl;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] expect_px(int hh, int vv);
    logic       vis, hs, vs;
    logic [2:0] c;
    vis = (hh < 640) && (vv < 480);
    hs  = !(hh >= 656 && hh < 752);
    vs  = !(vv >= 490 && vv < 492);
    c   = 3'b000;
    if (vis) c = fb[(vv / 4) * 160 + hh / 4];
    return {hs, vs, vis, {10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
  endfunction

  task automatic wr(int xx, int yy, logic [2:0] c);
    @(negedge clock);
    x = 8'(xx); y = 7'(yy); colour = c; plot = 1'b1;
    @(posedge clock);
    if (xx < 160 && yy < 120) fb[yy * 160 + xx] = c;
    #1 plot = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    h = 0; v = 0; ph = 1'b0; cyc = 0;
    prev_hs = 1'b1; prev_bl = 1'b0;
    sb.delete();
    sb.push_back(IDLE);
  endtask

  task automatic step();
    logic [33:0] exp;
    sb.push_back(expect_px(h, v));
    @(posedge clock);
    if (ph) begin
      if (h == 799) begin h = 0; v = (v == 524) ? 0 : v + 1; end
      else h++;
    end
    ph = !ph;
    cyc++;
    #1;
    exp = sb.pop_front();
    check($sformatf("pixel@%0d", cyc), 64'({VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B}), 64'(exp));
    check($sformatf("vga_clk@%0d", cyc), 64'(VGA_CLK), 64'(ph));
    if (prev_hs && !VGA_HS) begin
      if (hs_fall1 < 0) hs_fall1 = cyc;
      else if (hs_fall2 < 0) hs_fall2 = cyc;
    end
    if (!prev_hs && VGA_HS && hs_fall1 >= 0 && hs_rise < 0) hs_rise = cyc;
    if (!prev_bl && VGA_BLANK && bl_rise < 0) bl_rise = cyc;
    if (prev_bl && !VGA_BLANK && bl_rise >= 0 && bl_fall < 0) bl_fall = cyc;
    prev_hs = VGA_HS;
    prev_bl = VGA_BLANK;
    if (VGA_R != '0) lit_r++;
    if (VGA_B == 10'h3FF) lit_b++;
  endtask

  initial begin
    foreach (fb[i]) fb[i] = 3'b000;

    // Reset held while rows 0..3 are cleared and the test pixels are written
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 160; xx++) wr(xx, yy, 3'b000);
    wr(5, 3, 3'b110);
    wr(160, 0, 3'b111);
    #1;
    check("reset_outputs", 64'({VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B}), 64'(IDLE));
    check("reset_vga_clk", 64'(VGA_CLK), 64'(0));
    check("vga_sync", 64'(VGA_SYNC), 64'(1));

    // Scan from reset to the middle of line 8
    release_reset();
    lit_r = 0;
    for (int i = 0; i < 8 * 1600 + 400; i++) step();
    check("hs_first_fall", 64'(hs_fall1), 64'(2 * 656 + 2));
    check("hs_period", 64'(hs_fall2 - hs_fall1), 64'(1600));
    check("hs_low", 64'(hs_rise - hs_fall1), 64'(192));
    check("blank_high", 64'(bl_fall - bl_rise), 64'(1280));
    check("no_lit_rows_0_2", 64'(lit_r), 64'(0));

    // Mid-frame reset: counters restart, plotted pixel appears on lines 12..15
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("midframe_reset_outputs", 64'({VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B}), 64'(IDLE));
    check("midframe_reset_vga_clk", 64'(VGA_CLK), 64'(0));
    release_reset();
    lit_r = 0;
    for (int i = 0; i < 16 * 1600; i++) step();
    check("plot_pixel_clocks", 64'(lit_r), 64'(32));

    // Fill the whole framebuffer with blue under reset, then scan lines 0..3
    @(negedge clock);
    reset = 1'b1;
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++) wr(xx, yy, 3'b001);
    release_reset();
    lit_b = 0;
    for (int i = 0; i < 4 * 1600; i++) step();
    check("fill_blue_clocks", 64'(lit_b), 64'(4 * 1280));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
